// File: rtl/drop_command_sequencer_if.sv
// Byte-level link between the UART rx/tx pair and the drop command sequencer.
// Rx side: rx_data qualified by the one-cycle new_rx_data strobe. Tx side: tx_data taken on the one-cycle new_tx_data strobe, which is only raised when tx_block was low.
interface drop_command_sequencer_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_block;

  // UART side: supplies received bytes and the transmitter busy flag.
  modport master (
    output rx_data,
    output new_rx_data,
    output tx_block,
    input  tx_data,
    input  new_tx_data
  );

  // Sequencer side.
  modport slave (
    input  rx_data,
    input  new_rx_data,
    input  tx_block,
    output tx_data,
    output new_tx_data
  );
endinterface

// File: rtl/drop_command_sequencer.sv
// Arm-then-fire payload release sequencer: decodes command bytes, times the
// arming window and release hold with one counter, and acks every command.
module drop_command_sequencer #(
  parameter int ARM_TIMEOUT = 50_000_000,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CTR_W       = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  drop_command_sequencer_if.slave       bus,
  output logic                          drop,
  output logic                          armed,
  output logic [7:0]                    debug
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DROP  = 3'd2
  } state_t;

  localparam logic [7:0] CMD_ARM    = 8'hA5;
  localparam logic [7:0] CMD_FIRE   = 8'hD7;
  localparam logic [7:0] CMD_DISARM = 8'h00;

  localparam logic [7:0] ACK_ARMED   = 8'h41;
  localparam logic [7:0] ACK_DROP    = 8'h44;
  localparam logic [7:0] ACK_DISARM  = 8'h58;
  localparam logic [7:0] ACK_REJECT  = 8'h3F;
  localparam logic [7:0] ACK_TIMEOUT = 8'h54;
  localparam logic [7:0] ACK_DONE    = 8'h43;

  localparam logic [CTR_W-1:0] ARM_LAST  = CTR_W'(ARM_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] HOLD_LAST = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             drop_q;
  logic             armed_q;
  logic             pending_q;
  logic [7:0]       ack_byte_q;
  logic [7:0]       tx_data_q;
  logic             new_tx_q;
  logic             ack_vld_d;
  logic [7:0]       ack_val_d;
  logic             send_d;

  // Next-state decode. A byte in the expiry cycle is handled first; bytes
  // ignored while dropping do not hold off the hold expiry.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    ack_vld_d = 1'b0;
    ack_val_d = 8'h00;
    case (state_q)
      ST_IDLE: begin
        ctr_d = '0;
        if (bus.new_rx_data) begin
          ack_vld_d = 1'b1;
          case (bus.rx_data)
            CMD_ARM: begin
              state_d   = ST_ARMED;
              ack_val_d = ACK_ARMED;
            end
            CMD_DISARM: ack_val_d = ACK_DISARM;
            default:    ack_val_d = ACK_REJECT;
          endcase
        end
      end

      ST_ARMED: begin
        ctr_d = ctr_q + CTR_ONE;
        if (bus.new_rx_data) begin
          ack_vld_d = 1'b1;
          ctr_d     = '0;
          case (bus.rx_data)
            CMD_ARM: ack_val_d = ACK_ARMED;
            CMD_FIRE: begin
              state_d   = ST_DROP;
              ack_val_d = ACK_DROP;
            end
            CMD_DISARM: begin
              state_d   = ST_IDLE;
              ack_val_d = ACK_DISARM;
            end
            default: begin
              state_d   = ST_IDLE;
              ack_val_d = ACK_REJECT;
            end
          endcase
        end else if (ctr_q == ARM_LAST) begin
          state_d   = ST_IDLE;
          ctr_d     = '0;
          ack_vld_d = 1'b1;
          ack_val_d = ACK_TIMEOUT;
        end
      end

      ST_DROP: begin
        ctr_d = ctr_q + CTR_ONE;
        if (bus.new_rx_data && (bus.rx_data == CMD_DISARM)) begin
          state_d   = ST_IDLE;
          ctr_d     = '0;
          ack_vld_d = 1'b1;
          ack_val_d = ACK_DISARM;
        end else if (ctr_q == HOLD_LAST) begin
          state_d   = ST_IDLE;
          ctr_d     = '0;
          ack_vld_d = 1'b1;
          ack_val_d = ACK_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  // The strobe gap keeps new_tx_data from firing on back-to-back cycles.
  assign send_d = pending_q && !bus.tx_block && !new_tx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      drop_q     <= 1'b0;
      armed_q    <= 1'b0;
      pending_q  <= 1'b0;
      ack_byte_q <= 8'h00;
      tx_data_q  <= 8'h00;
      new_tx_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      drop_q   <= (state_d == ST_DROP);
      armed_q  <= (state_d == ST_ARMED);
      new_tx_q <= send_d;
      if (send_d) begin
        tx_data_q <= ack_byte_q;
      end
      // A fresh ack overrides both the slot clear and any unsent older ack.
      if (ack_vld_d) begin
        pending_q  <= 1'b1;
        ack_byte_q <= ack_val_d;
      end else if (send_d) begin
        pending_q  <= 1'b0;
      end
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;
  assign drop            = drop_q;
  assign armed           = armed_q;
  assign debug           = {4'b0000, pending_q, state_q};

endmodule

// File: tb/tb_drop_command_sequencer.sv
// Directed test of drop_command_sequencer: stimulus pushes expected ack bytes,
// a monitor pops them whenever the sequencer strobes new_tx_data.
module tb_drop_command_sequencer;

  logic       clk;
  logic       rst;
  logic       drop;
  logic       armed;
  logic [7:0] debug;

  drop_command_sequencer_if bus_if ();

  drop_command_sequencer #(
    .ARM_TIMEOUT(20),
    .HOLD_CYCLES(10),
    .CTR_W      (27)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if.slave),
    .drop (drop),
    .armed(armed),
    .debug(debug)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         strobe_cnt = 0;
  logic       blk_at_edge = 1'b0;
  logic       prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) blk_at_edge <= bus_if.tx_block;

  always @(negedge clk) begin
    if (!rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (bus_if.new_tx_data) begin
        strobe_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ack: got %0h expected none at %0t", bus_if.tx_data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus_if.tx_data !== e) begin
            n_err++;
            $display("FAIL ack_byte: got %0h expected %0h at %0t", bus_if.tx_data, e, $time);
          end
        end
        if (prev_strobe) begin
          n_err++;
          $display("FAIL strobe_gap: got back-to-back strobes expected gap at %0t", $time);
        end
        if (blk_at_edge) begin
          n_err++;
          $display("FAIL strobe_blocked: got strobe expected none while tx_block at %0t", $time);
        end
      end
      prev_strobe = bus_if.new_tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 ns after an edge; byte is sampled at the next edge, returns 1 ns after it.
  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data     = b;
    bus_if.new_rx_data = 1'b1;
    @(posedge clk);
    #1;
    bus_if.new_rx_data = 1'b0;
    bus_if.rx_data     = 8'h00;
  endtask

  // Counts consecutive post-edge samples (starting now) where the chosen signal is high.
  task automatic count_high(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? armed : drop) && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int n_hi;
  int strobe_snap;

  initial begin
    rst                = 1'b0;
    bus_if.rx_data     = 8'h00;
    bus_if.new_rx_data = 1'b0;
    bus_if.tx_block    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_drop", {31'd0, drop}, 32'd0);
    check("reset_armed", {31'd0, armed}, 32'd0);
    check("reset_new_tx", {31'd0, bus_if.new_tx_data}, 32'd0);
    check("reset_tx_data", {24'd0, bus_if.tx_data}, 32'h00);
    check("reset_debug", {24'd0, debug}, 32'h00);
    rst = 1'b1;
    wait_cycles(2);

    // Arm then fire three cycles later.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h43);
    send_byte(8'hA5);
    check("arm_armed_c0", {31'd0, armed}, 32'd1);
    check("arm_state", {29'd0, debug[2:0]}, 32'd1);
    wait_cycles(1);
    check("arm_armed_c1", {31'd0, armed}, 32'd1);
    wait_cycles(1);
    check("arm_armed_c2", {31'd0, armed}, 32'd1);
    send_byte(8'hD7);
    check("fire_armed_low", {31'd0, armed}, 32'd0);
    check("fire_state", {29'd0, debug[2:0]}, 32'd2);
    count_high(1, n_hi);
    check("hold_len", n_hi, 32'd10);
    wait_cycles(4);
    check("hold_done_state", {29'd0, debug[2:0]}, 32'd0);

    // FIRE from IDLE is rejected.
    exp_q.push_back(8'h3F);
    send_byte(8'hD7);
    check("idle_fire_drop", {31'd0, drop}, 32'd0);
    check("idle_fire_state", {29'd0, debug[2:0]}, 32'd0);
    wait_cycles(4);

    // Arming timeout, then FIRE landing on the timeout cycle.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h54);
    send_byte(8'hA5);
    count_high(0, n_hi);
    check("arm_timeout_len", n_hi, 32'd20);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h43);
    send_byte(8'hA5);
    wait_cycles(19);
    send_byte(8'hD7);
    check("race_fire_drop", {31'd0, drop}, 32'd1);
    check("race_fire_armed", {31'd0, armed}, 32'd0);
    count_high(1, n_hi);
    check("race_hold_len", n_hi, 32'd10);
    wait_cycles(4);

    // DISARM aborts the drop at cycle 4.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h58);
    send_byte(8'hA5);
    send_byte(8'hD7);
    wait_cycles(3);
    check("abort_pre_drop", {31'd0, drop}, 32'd1);
    send_byte(8'h00);
    check("abort_drop", {31'd0, drop}, 32'd0);
    check("abort_state", {29'd0, debug[2:0]}, 32'd0);
    wait_cycles(4);

    // FIRE at cycle 4 of the drop is ignored; full hold follows.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h43);
    send_byte(8'hA5);
    send_byte(8'hD7);
    wait_cycles(3);
    send_byte(8'hD7);
    count_high(1, n_hi);
    check("ignored_fire_rest", n_hi, 32'd6);
    wait_cycles(4);
    check("ignored_fire_pending", {31'd0, debug[3]}, 32'd0);

    // tx_block held across A5 then 00: only 58 goes out after release.
    bus_if.tx_block = 1'b1;
    strobe_snap = strobe_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    wait_cycles(5);
    check("blocked_no_strobe", strobe_cnt - strobe_snap, 32'd0);
    check("blocked_pending", {31'd0, debug[3]}, 32'd1);
    exp_q.push_back(8'h58);
    bus_if.tx_block = 1'b0;
    wait_cycles(4);
    check("unblock_one_strobe", strobe_cnt - strobe_snap, 32'd1);
    check("unblock_pending", {31'd0, debug[3]}, 32'd0);

    // Asynchronous reset in the middle of a drop.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h44);
    send_byte(8'hA5);
    send_byte(8'hD7);
    wait_cycles(4);
    check("pre_rst_drop", {31'd0, drop}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_drop", {31'd0, drop}, 32'd0);
    check("async_rst_armed", {31'd0, armed}, 32'd0);
    check("async_rst_new_tx", {31'd0, bus_if.new_tx_data}, 32'd0);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(3);
    check("post_rst_state", {29'd0, debug[2:0]}, 32'd0);
    check("post_rst_drop", {31'd0, drop}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
